instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage and IF/ID pipeline register that sits directly upstream of the next-instruction calculator. It owns the program counter, issues instruction-memory requests, captures the returned word together with PC+4 into the IF/ID register, and applies redirects (taken branch/jump targets) computed by decode from that same IF/ID content. It absorbs hazard-unit stalls and variable instruction-memory latency without losing or duplicating instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Stall  in  1  hazard unit: hold IF/ID contents this cycle
- Redirect  in  1  decode: the instruction in IF/ID is a taken branch/jump
- RedirectAddress  in  32  target from the next-instruction calculator; bits [1:0] ignored (treated as 0)
- IMemAddr  out  32  fetch address (current PC)
- IMemReq  out  1  fetch request
- IMemReady  in  1  memory: IMemData is valid for the IMemAddr presented this cycle
- IMemData  in  32  instruction word
- Instr_PC_Plus4  out  32  IF/ID: fetched PC + 4
- Instruction  out  32  IF/ID: fetched instruction word
- InstrValid  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Registers: PC, IF/ID {Instr_PC_Plus4, Instruction, InstrValid}, one-entry skid buffer {data, pc4, valid}, saved target, FSM state.
- Memory handshake: memory samples IMemAddr in the cycle IMemReady=1; IMemAddr may change in any cycle (no abort needed). "Response" = IMemReq & IMemReady.
- IMemReq = 1 in FETCH and DS_WAIT, 0 in HOLD and while reset is asserted. IMemAddr = PC always.
- FSM states:
  - FETCH: response & !Stall -> IF/ID <= {PC+4, IMemData, 1}, PC <= PC+4. Response & Stall -> skid <= {IMemData, PC+4}, PC <= PC+4, go HOLD. No response & !Stall -> IF/ID.InstrValid <= 0 (bubble), data fields hold.
  - HOLD: no fetch. When Stall=0: IF/ID <= skid, skid.valid <= 0, go FETCH.
  - DS_WAIT (delay-slot mode only): fetching the delay slot; on response & !Stall -> IF/ID <= delay slot, PC <= saved target, go FETCH; on response & Stall -> skid <= delay slot, PC <= saved target, go HOLD.
- Redirect is qualified by !Stall; Redirect with Stall=1 is ignored (hazard unit never asserts both).
- Redirect handling (non-delay-slot build): PC <= RedirectAddress; any response in that cycle is discarded; skid.valid <= 0; IF/ID.InstrValid <= 0; state <= FETCH.
- Redirect handling (delay-slot build): see Configuration.
- Arithmetic: PC+4 modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset (async): PC=RESET_PC, Instruction=0, Instr_PC_Plus4=0, InstrValid=0, skid.valid=0, saved target=0, state=FETCH, IMemReq=0.

## Timing
- Latency: address presented in cycle N with IMemReady=1 -> IF/ID valid after edge N; steady state 1 instruction/cycle.
- Redirect sampled at edge N -> IMemAddr = target during cycle N+1 -> target in IF/ID after edge N+1 (1 bubble, non-delay-slot build).
- Stall: IF/ID unchanged on every edge with Stall=1; at most one response is buffered; PC advances past it only once.
- HOLD -> FETCH costs no extra bubble: skid drains on the first Stall=0 edge while IMemReq rises the next cycle.
- Reset deasserted mid-fetch: first request at RESET_PC in the cycle after release.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: the instruction at branch PC+4 is kept. On Redirect: if skid.valid or a response arrives that cycle, that word is the delay slot -> enters IF/ID (or stays in skid), PC <= RedirectAddress; otherwise save target, go DS_WAIT.
- Undefined: delay slot squashed as in Operation; DS_WAIT unreachable.

## Test plan
- Reset, IMemReady=1 always, sequential words -> IMemAddr 0,4,8,…; Instr_PC_Plus4 4,8,12 on consecutive edges, InstrValid=1 from first edge.
- Stall=1 for 3 cycles while IMemReady=1 -> IF/ID frozen, exactly one word buffered, IMemReq=0, no skipped/duplicated PC after release.
- Redirect to 0x0000_0100 with word at 0x0C in flight (no DS macro) -> one bubble, IMemAddr=0x100 next cycle, word at 0x0C never appears.
- Same with BRANCH_DELAY_SLOT_EN and IMemReady low in redirect cycle -> DS_WAIT, word at 0x0C enters IF/ID, then 0x100 fetched.
- RESET_PC=32'hFFFF_FFF8 -> IMemAddr FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset during HOLD -> all outputs to reset values immediately, skid emptied.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Fetch stage and IF/ID register: owns the PC, issues instruction-memory requests, absorbs stalls
// in a one-entry skid buffer and applies decode redirects. Optional build macro: BRANCH_DELAY_SLOT_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddress,
    output logic [31:0] IMemAddr,
    output logic        IMemReq,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr_PC_Plus4,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [1:0]  DebugState
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DS_WAIT = 2'd2
    } fetchState_t;

    fetchState_t state, nextState;

    logic [31:0] pc, nextPc;
    logic [31:0] ifPc4, nextIfPc4;
    logic [31:0] ifInstr, nextIfInstr;
    logic        ifValid, nextIfValid;
    logic [31:0] skidData, nextSkidData;
    logic [31:0] skidPc4, nextSkidPc4;
    logic        skidValid, nextSkidValid;
    logic [31:0] savedTarget, nextSavedTarget;

    logic        response;
    logic        takeRedirect;
    logic [31:0] target;
    logic [31:0] pcPlus4;

    // Handshake: a word is accepted only in a cycle with IMemReq=1 and IMemReady=1; it belongs to the
    // IMemAddr presented in that same cycle. IMemAddr may move freely while IMemReady=0.
    assign IMemAddr       = pc;
    assign IMemReq        = !reset && (state != HOLD);
    assign Instr_PC_Plus4 = ifPc4;
    assign Instruction    = ifInstr;
    assign InstrValid     = ifValid;
    assign DebugState     = state;

    assign response     = IMemReq && IMemReady;
    assign takeRedirect = Redirect && !Stall;
    assign target       = RedirectAddress & ~32'h0000_0003;
    assign pcPlus4      = pc + 32'd4;

    always_comb begin
        nextState       = state;
        nextPc          = pc;
        nextIfPc4       = ifPc4;
        nextIfInstr     = ifInstr;
        nextIfValid     = ifValid;
        nextSkidData    = skidData;
        nextSkidPc4     = skidPc4;
        nextSkidValid   = skidValid;
        nextSavedTarget = savedTarget;

        case (state)
            FETCH: begin
                if (takeRedirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    // The word at branch PC+4 is the delay slot; keep it if it arrives now.
                    if (response) begin
                        nextIfPc4   = pcPlus4;
                        nextIfInstr = IMemData;
                        nextIfValid = 1'b1;
                        nextPc      = target;
                    end else begin
                        nextSavedTarget = target;
                        nextIfValid     = 1'b0;
                        nextState       = DS_WAIT;
                    end
`else
                    nextPc        = target;
                    nextIfValid   = 1'b0;
                    nextSkidValid = 1'b0;
`endif
                end else if (response) begin
                    nextPc = pcPlus4;
                    if (Stall) begin
                        nextSkidData  = IMemData;
                        nextSkidPc4   = pcPlus4;
                        nextSkidValid = 1'b1;
                        nextState     = HOLD;
                    end else begin
                        nextIfPc4   = pcPlus4;
                        nextIfInstr = IMemData;
                        nextIfValid = 1'b1;
                    end
                end else if (!Stall) begin
                    nextIfValid = 1'b0;
                end
            end

            HOLD: begin
                if (!Stall) begin
                    nextSkidValid = 1'b0;
                    nextState     = FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                    nextIfPc4   = skidPc4;
                    nextIfInstr = skidData;
                    nextIfValid = 1'b1;
                    if (takeRedirect) nextPc = target;
`else
                    if (takeRedirect) begin
                        nextPc      = target;
                        nextIfValid = 1'b0;
                    end else begin
                        nextIfPc4   = skidPc4;
                        nextIfInstr = skidData;
                        nextIfValid = 1'b1;
                    end
`endif
                end
            end

            DS_WAIT: begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (response) begin
                    nextPc    = savedTarget;
                    nextState = FETCH;
                    if (Stall) begin
                        nextSkidData  = IMemData;
                        nextSkidPc4   = pcPlus4;
                        nextSkidValid = 1'b1;
                        nextState     = HOLD;
                    end else begin
                        nextIfPc4   = pcPlus4;
                        nextIfInstr = IMemData;
                        nextIfValid = 1'b1;
                    end
                end else if (!Stall) begin
                    nextIfValid = 1'b0;
                end
`else
                nextState = FETCH;
`endif
            end

            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            ifPc4       <= 32'd0;
            ifInstr     <= 32'd0;
            ifValid     <= 1'b0;
            skidData    <= 32'd0;
            skidPc4     <= 32'd0;
            skidValid   <= 1'b0;
            savedTarget <= 32'd0;
        end else begin
            state       <= nextState;
            pc          <= nextPc;
            ifPc4       <= nextIfPc4;
            ifInstr     <= nextIfInstr;
            ifValid     <= nextIfValid;
            skidData    <= nextSkidData;
            skidPc4     <= nextSkidPc4;
            skidValid   <= nextSkidValid;
            savedTarget <= nextSavedTarget;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: transaction-level model compared every cycle,
// plus directed literal expectations. Honors BRANCH_DELAY_SLOT_EN when defined.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectAddress;
    logic        IMemReady;
    logic [31:0] IMemAddr, IMemData, Instr_PC_Plus4, Instruction;
    logic        IMemReq, InstrValid;
    logic [1:0]  DebugState;
    logic [31:0] IMemAddr2, IMemData2, Instr_PC_Plus4_2, Instruction2;
    logic        IMemReq2, InstrValid2;
    logic [1:0]  DebugState2;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign IMemData  = memWord(IMemAddr);
    assign IMemData2 = memWord(IMemAddr2);

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectAddress(RedirectAddress), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
        .IMemReady(IMemReady), .IMemData(IMemData), .Instr_PC_Plus4(Instr_PC_Plus4),
        .Instruction(Instruction), .InstrValid(InstrValid), .DebugState(DebugState)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dutHigh (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectAddress(RedirectAddress), .IMemAddr(IMemAddr2), .IMemReq(IMemReq2),
        .IMemReady(IMemReady), .IMemData(IMemData2), .Instr_PC_Plus4(Instr_PC_Plus4_2),
        .Instruction(Instruction2), .InstrValid(InstrValid2), .DebugState(DebugState2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Program-order view: mPc is the next address to fetch, exp_q holds at most one buffered word.
    logic [31:0] mPc = 32'd0;
    logic [31:0] mIfPc4 = 32'd0;
    logic [31:0] mIfInstr = 32'd0;
    logic        mIfValid = 1'b0;
    logic        mWait = 1'b0;
    logic [31:0] mSaved = 32'd0;
    logic [31:0] exp_q[$];
    logic [31:0] expPc4_q[$];
    logic        mResp;
    logic [31:0] mTgt;

    task automatic modelAccept();
        if (Stall) begin
            exp_q.push_back(memWord(mPc));
            expPc4_q.push_back(mPc + 32'd4);
        end else begin
            mIfPc4   = mPc + 32'd4;
            mIfInstr = memWord(mPc);
            mIfValid = 1'b1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPc = 32'd0; mIfPc4 = 32'd0; mIfInstr = 32'd0; mIfValid = 1'b0;
            mWait = 1'b0; mSaved = 32'd0;
            exp_q.delete(); expPc4_q.delete();
        end else begin
            mResp = (exp_q.size() == 0) && IMemReady;
            mTgt  = {RedirectAddress[31:2], 2'b00};
            if (exp_q.size() != 0) begin
                if (!Stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    mIfInstr = exp_q.pop_front(); mIfPc4 = expPc4_q.pop_front(); mIfValid = 1'b1;
                    if (Redirect) mPc = mTgt;
`else
                    if (Redirect) begin
                        exp_q.delete(); expPc4_q.delete(); mIfValid = 1'b0; mPc = mTgt;
                    end else begin
                        mIfInstr = exp_q.pop_front(); mIfPc4 = expPc4_q.pop_front(); mIfValid = 1'b1;
                    end
`endif
                end
            end else if (mWait) begin
                if (mResp) begin
                    modelAccept(); mPc = mSaved; mWait = 1'b0;
                end else if (!Stall) mIfValid = 1'b0;
            end else if (Redirect && !Stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (mResp) begin
                    modelAccept(); mPc = mTgt;
                end else begin
                    mSaved = mTgt; mWait = 1'b1; mIfValid = 1'b0;
                end
`else
                mPc = mTgt; mIfValid = 1'b0;
`endif
            end else if (mResp) begin
                modelAccept(); mPc = mPc + 32'd4;
            end else if (!Stall) mIfValid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_IMemAddr", IMemAddr, mPc);
        chk("cyc_IMemReq", {31'd0, IMemReq}, {31'd0, !reset && exp_q.size() == 0});
        chk("cyc_InstrValid", {31'd0, InstrValid}, {31'd0, mIfValid});
        chk("cyc_Instr_PC_Plus4", Instr_PC_Plus4, mIfPc4);
        chk("cyc_Instruction", Instruction, mIfInstr);
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [2:0]  vecCtl[16];
    logic [31:0] vecRa[16];

    initial begin
        Stall = 1'b0; Redirect = 1'b0; RedirectAddress = 32'd0; IMemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_IMemReq", {31'd0, IMemReq}, 32'd0);
        chk("rst_IMemAddr", IMemAddr, 32'd0);
        chk("rst_InstrValid", {31'd0, InstrValid}, 32'd0);
        chk("rst_Instruction", Instruction, 32'd0);
        chk("rst_IMemAddr_high", IMemAddr2, 32'hFFFF_FFF8);
        tick(); tick();

        // Sequential fetch, memory always ready
        reset = 1'b0; #1;
        chk("seq_req", {31'd0, IMemReq}, 32'd1);
        chk("seq_addr0", IMemAddr, 32'd0);
        tick();
        chk("seq_pc4_1", Instr_PC_Plus4, 32'd4);
        chk("seq_instr_1", Instruction, 32'h1357_9BDF);
        chk("seq_valid_1", {31'd0, InstrValid}, 32'd1);
        chk("seq_addr_1", IMemAddr, 32'd4);
        chk("wrap_addr_1", IMemAddr2, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", Instr_PC_Plus4_2, 32'hFFFF_FFFC);
        tick();
        chk("seq_pc4_2", Instr_PC_Plus4, 32'd8);
        chk("wrap_addr_2", IMemAddr2, 32'h0000_0000);
        chk("wrap_pc4_2", Instr_PC_Plus4_2, 32'h0000_0000);
        tick();
        chk("seq_pc4_3", Instr_PC_Plus4, 32'd12);
        chk("seq_instr_3", Instruction, 32'h1357_9BD7);
        chk("wrap_addr_3", IMemAddr2, 32'h0000_0004);

        // Three-cycle stall with memory ready
        Stall = 1'b1;
        tick();
        chk("stall_req", {31'd0, IMemReq}, 32'd0);
        chk("stall_addr", IMemAddr, 32'd16);
        tick(); tick();
        chk("stall_pc4_frozen", Instr_PC_Plus4, 32'd12);
        Stall = 1'b0;
        tick();
        chk("drain_pc4", Instr_PC_Plus4, 32'd16);
        chk("drain_instr", Instruction, 32'h1357_9BD3);
        chk("drain_req", {31'd0, IMemReq}, 32'd1);
        chk("drain_addr", IMemAddr, 32'd16);
        tick();
        chk("after_drain_pc4", Instr_PC_Plus4, 32'd20);

        // Redirect while the word at 0x0C is being returned
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick(); tick();
        chk("pre_redir_pc4", Instr_PC_Plus4, 32'd12);
        Redirect = 1'b1; RedirectAddress = 32'h0000_0103;
`ifdef BRANCH_DELAY_SLOT_EN
        IMemReady = 1'b0;
        tick();
        Redirect = 1'b0; IMemReady = 1'b1;
        chk("ds_wait_valid", {31'd0, InstrValid}, 32'd0);
        chk("ds_wait_addr", IMemAddr, 32'd12);
        tick();
        chk("ds_slot_pc4", Instr_PC_Plus4, 32'd16);
        chk("ds_slot_instr", Instruction, 32'h1357_9BD3);
        chk("ds_target_addr", IMemAddr, 32'h0000_0100);
        tick();
        chk("ds_target_pc4", Instr_PC_Plus4, 32'h0000_0104);
`else
        tick();
        Redirect = 1'b0;
        chk("redir_bubble", {31'd0, InstrValid}, 32'd0);
        chk("redir_addr", IMemAddr, 32'h0000_0100);
        tick();
        chk("redir_pc4", Instr_PC_Plus4, 32'h0000_0104);
        chk("redir_instr", Instruction, 32'h1357_9ADF);
        chk("redir_valid", {31'd0, InstrValid}, 32'd1);
`endif

        // Mixed latency / stall / redirect vectors: {Stall, IMemReady, Redirect}
        vecCtl = '{3'b010, 3'b000, 3'b010, 3'b110, 3'b100, 3'b011, 3'b010, 3'b001,
                   3'b010, 3'b100, 3'b110, 3'b000, 3'b011, 3'b010, 3'b110, 3'b010};
        vecRa  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h302,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 16; i++) begin
            {Stall, IMemReady, Redirect} = vecCtl[i];
            RedirectAddress = vecRa[i];
            tick();
        end
        Stall = 1'b0; IMemReady = 1'b1; Redirect = 1'b0;
        tick(); tick();

        // Reset asserted while holding a buffered word
        Stall = 1'b1;
        tick();
        chk("hold_req", {31'd0, IMemReq}, 32'd0);
        reset = 1'b1; #1;
        chk("hold_rst_req", {31'd0, IMemReq}, 32'd0);
        chk("hold_rst_addr", IMemAddr, 32'd0);
        chk("hold_rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("hold_rst_pc4", Instr_PC_Plus4, 32'd0);
        chk("hold_rst_instr", Instruction, 32'd0);
        tick();
        Stall = 1'b0; reset = 1'b0; #1;
        chk("post_rst_req", {31'd0, IMemReq}, 32'd1);
        chk("post_rst_addr", IMemAddr, 32'd0);
        tick();
        chk("post_rst_pc4", Instr_PC_Plus4, 32'd4);
        chk("post_rst_instr", Instruction, 32'h1357_9BDF);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
